// File: rtl/rtl.sv
// ---------------------------------------------------------------------------
// rtl : fixed-point tan(x) engine
//
// Evaluates tan(x) ~= x + c1*x^3 + c2*x^5 + c3*x^7 + c4*x^9 with one shared
// 16x16 multiplier. Every product is truncated to its upper 16 bits.
//
// Ports
//   ready  out  1   one-cycle pulse, result valid
//   clk    in   1   rising-edge clock
//   rst    in   1   asynchronous active-high reset
//   start  in   1   request (level, may be held several cycles)
//   x      in   16  argument, unsigned Q0.16
//   busy   out  1   high while a request is being accepted or computed
//   result out  16  tan(x), unsigned Q2.14, held until the next completion
// ---------------------------------------------------------------------------
module rtl (
  output logic        ready,
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] x,
  output logic        busy,
  output logic [15:0] result
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] INIT = 3'd2;
  localparam logic [2:0] MUL  = 3'd3;
  localparam logic [2:0] ADD  = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  // Series coefficients, unsigned Q0.16
  localparam logic [15:0] C1 = 16'd21845;  // 1/3
  localparam logic [15:0] C2 = 16'd8738;   // 2/15
  localparam logic [15:0] C3 = 16'd3537;   // 17/315
  localparam logic [15:0] C4 = 16'd1433;   // 62/2835

  logic [2:0]  state_r;
  logic [15:0] xr_r;
  logic [15:0] x2_r;
  logic [15:0] term_r;
  logic [17:0] acc_r;
  logic [2:0]  i_r;
  logic [15:0] result_r;

  logic [15:0] op_a_s;
  logic [15:0] op_b_s;
  logic [15:0] prod_s;
  logic [17:0] acc_sum_s;

  // Unsigned 16x16 multiply keeping only bits [31:16] (truncation, no rounding)
  function automatic logic [15:0] mulhi(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'd0, a} * {16'd0, b};
    return p[31:16];
  endfunction

  // Coefficient for term index idx
  function automatic logic [15:0] coef(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = C1;
      3'd1:    c = C2;
      3'd2:    c = C3;
      3'd3:    c = C4;
      default: c = 16'd0;
    endcase
    return c;
  endfunction

  // Operand steering for the single shared multiplier
  always_comb begin
    op_a_s = 16'd0;
    op_b_s = 16'd0;
    case (state_r)
      INIT: begin
        op_a_s = xr_r;
        op_b_s = xr_r;
      end
      MUL: begin
        op_a_s = term_r;
        op_b_s = x2_r;
      end
      ADD: begin
        op_a_s = term_r;
        op_b_s = coef(i_r);
      end
      default: begin
        op_a_s = 16'd0;
        op_b_s = 16'd0;
      end
    endcase
  end

  assign prod_s    = mulhi(op_a_s, op_b_s);
  assign acc_sum_s = acc_r + {2'b00, prod_s};

  // Controller and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      xr_r     <= 16'd0;
      x2_r     <= 16'd0;
      term_r   <= 16'd0;
      acc_r    <= 18'd0;
      i_r      <= 3'd0;
      result_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          // Sampling here too means a one-cycle start still captures its x
          if (start) begin
            state_r <= LOAD;
            xr_r    <= x;
          end
        end
        LOAD: begin
          if (start) begin
            xr_r <= x;
          end else begin
            state_r <= INIT;
          end
        end
        INIT: begin
          x2_r    <= prod_s;
          term_r  <= xr_r;
          acc_r   <= {2'b00, xr_r};
          i_r     <= 3'd0;
          state_r <= MUL;
        end
        MUL: begin
          term_r  <= prod_s;
          state_r <= ADD;
        end
        ADD: begin
          acc_r <= acc_sum_s;
          i_r   <= i_r + 3'd1;
          if (i_r == 3'd3) begin
            // Result is captured on the edge that enters DONE so it is
            // valid in the same cycle ready is high
            result_r <= acc_sum_s[17:2];
            state_r  <= DONE;
          end else begin
            state_r <= MUL;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Moore status decode from the registered state
  always_comb begin
    ready = (state_r == DONE);
    busy  = (state_r == LOAD) || (state_r == INIT) ||
            (state_r == MUL)  || (state_r == ADD);
  end

  assign result = result_r;

endmodule

// File: tb/tb_rtl.sv
module tb_rtl;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x     = 16'd0;
  logic        ready;
  logic        busy;
  logic [15:0] result;

  int tests = 0;
  int fails = 0;

  rtl dut (
    .ready (ready),
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .busy  (busy),
    .result(result)
  );

  always #20 clk = ~clk;

  // Reference arithmetic: truncated Maclaurin series, plain integer math
  function automatic logic [15:0] tan_model(input logic [15:0] xv);
    longint unsigned c [4];
    longint unsigned x2, term, acc;
    c    = '{64'd21845, 64'd8738, 64'd3537, 64'd1433};
    x2   = (longint'(xv) * longint'(xv)) >> 16;
    term = longint'(xv);
    acc  = longint'(xv);
    for (int k = 0; k < 4; k++) begin
      term = (term * x2) >> 16;
      acc  = acc + ((term * c[k]) >> 16);
    end
    return 16'(acc >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: loading phase, then a fixed 10-cycle countdown
  // (cycle count remaining until idle); the last cycle is the ready cycle.
  bit          m_load;
  int          m_cnt;
  logic [15:0] m_xr;
  logic [15:0] m_pend;
  logic [15:0] m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_load <= 1'b0;
      m_cnt  <= 0;
      m_xr   <= 16'd0;
      m_pend <= 16'd0;
      m_res  <= 16'd0;
    end else if (m_load) begin
      if (start) begin
        m_xr <= x;
      end else begin
        m_load <= 1'b0;
        m_cnt  <= 10;
        m_pend <= tan_model(m_xr);
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) m_res <= m_pend;
    end else if (start) begin
      m_load <= 1'b1;
      m_xr   <= x;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check("ready", {31'd0, ready}, {31'd0, (m_cnt == 1)});
    check("busy",  {31'd0, busy},  {31'd0, (m_load || m_cnt >= 2)});
    check("result", {16'd0, result}, {16'd0, m_res});
  end

  // One request: idle gap, start held n cycles (x random except the last),
  // then measure cycles from start falling to ready.
  task automatic req(input int gap, input int n, input logic [15:0] xlast,
                     input logic [15:0] want, input bit use_want, input string name);
    int lat;
    repeat (gap) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start = 1'b1;
      x     = (k == n - 1) ? xlast : 16'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    x     = 16'($urandom);
    lat   = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk);
      #1;
      if (ready) lat = c;
    end
    check({name, " latency"}, lat, 10);
    if (lat != 0) begin
      check({name, " result"}, {16'd0, result}, {16'd0, (use_want ? want : tan_model(xlast))});
    end
  endtask

  initial begin
    #10;
    check("reset ready",  {31'd0, ready}, 32'd0);
    check("reset busy",   {31'd0, busy},  32'd0);
    check("reset result", {16'd0, result}, 32'd0);
    #14 rst = 1'b0;

    // Hand-computed pins of the reference arithmetic
    check("model 0x8000", {16'd0, tan_model(16'h8000)}, 32'h22F6);
    check("model 0xFFFF", {16'd0, tan_model(16'hFFFF)}, 32'd25271);
    check("model 0x0000", {16'd0, tan_model(16'h0000)}, 32'd0);

    req(1, 2, 16'h8000, 16'h22F6, 1'b1, "half");
    req(2, 1, 16'h0000, 16'h0000, 1'b1, "zero");
    req(2, 1, 16'hFFFF, 16'd25271, 1'b1, "max");
    req(2, 5, 16'h1234, 16'h0000, 1'b0, "hold5");

    // Reset in the middle of the computation
    repeat (2) @(negedge clk);
    start = 1'b1;
    x     = 16'h8000;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #5;
    check("busy before abort", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort ready",  {31'd0, ready}, 32'd0);
    check("abort busy",   {31'd0, busy},  32'd0);
    check("abort result", {16'd0, result}, 32'd0);
    @(posedge clk);
    #7 rst = 1'b0;
    req(2, 1, 16'h4000, 16'h0000, 1'b0, "after abort");

    // Back-to-back: second start raised during the DONE cycle
    req(2, 2, 16'hC000, 16'h0000, 1'b0, "b2b first");
    req(0, 3, 16'h2000, 16'h0000, 1'b0, "b2b second");

    // Randomized requests
    for (int r = 0; r < 25; r++) begin
      req(2 + $urandom_range(0, 2), $urandom_range(1, 4), 16'($urandom), 16'h0000, 1'b0, "random");
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
